instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch stage of the multi-cycle RV32I core. Holds the PC and issues one request at a time to
//   instruction memory, which has variable latency. It presents each fetched instruction and its PC to the
//   decode/ControlUnit stage through a valid/ready handshake. It applies jal/jalr/branch redirects, including
//   those that arrive while a fetch is in flight, and stops fetching on an ecall halt.
// PARAMETERS
//   XLEN      32           width of PC and imem_addr
//   RESET_PC  32'h0        PC loaded on reset
//   CNT_W     32           width of retired-fetch counter
// PORTS
//   clk             in   1      single clock, all state on posedge
//   reset           in   1      asynchronous, active-low; 0 clears all state immediately
//   imem_req        out  1      one-cycle request pulse to instruction memory
//   imem_addr       out  XLEN   request address, equals pc_q; valid when imem_req=1
//   imem_rvalid     in   1      response strobe, >=1 cycle after imem_req
//   imem_rdata      in   32     instruction word, valid when imem_rvalid=1
//   if_valid        out  1      if_inst/if_pc hold a live instruction
//   if_ready        in   1      decode accepts; transfer when if_valid & if_ready
//   if_inst         out  32     fetched instruction
//   if_pc           out  XLEN   PC of if_inst
//   redirect_valid  in   1      one-cycle pulse: taken branch / jal / jalr
//   redirect_pc     in   XLEN   redirect target
//   halt            in   1      one-cycle pulse: ecall terminate, from decode
//   halted          out  1      fetch permanently stopped until reset
//   fetch_count     out  CNT_W  number of handshake transfers since reset
// BEHAVIOUR
//   Reset (reset=0, async) values:
//   - state=IDLE, pc_q=RESET_PC, drop_q=0.
//   - imem_req=0, if_valid=0, if_inst=32'h00000013 (NOP), if_pc=0, halted=0, fetch_count=0.
//   - Reset asserted mid-fetch abandons the fetch. Any imem_rvalid seen in IDLE is ignored.
//   States and transitions (all outputs registered):
//   - IDLE:   next cycle -> REQ. IDLE is entered only from reset.
//   - REQ:    imem_req=1 for exactly this cycle, imem_addr=pc_q -> WAIT.
//   - WAIT:   on imem_rvalid with drop_q=0: capture if_inst=imem_rdata, if_pc=pc_q; pc_q<=pc_q+4;
//             set if_valid=1 -> VALID.
//             On imem_rvalid with drop_q=1: discard the response, clear drop_q -> REQ (or HALTED if halt is pending).
//   - VALID:  if_valid=1, if_inst and if_pc stable. On if_valid&if_ready: fetch_count++, if_valid<=0 -> REQ.
//   - HALTED: imem_req=0, if_valid=0, halted=1. Only reset exits this state.
//   Resulting cadence: IDLE->REQ->WAIT->VALID; a fresh instruction appears at best every 3 cycles.
//   Redirect (redirect_valid=1, not HALTED):
//   - pc_q <= {redirect_pc[XLEN-1:2],2'b00}.
//   - VALID: if_valid<=0 with no transfer and no count, even if if_ready=1 in the same cycle -> REQ.
//   - REQ: the request still issues, drop_q<=1 -> WAIT.
//   - WAIT: drop_q<=1. If imem_rvalid arrives in the same cycle, that response is discarded -> REQ.
//   - Multiple redirects during one WAIT: the last target wins.
//   Halt:
//   - halt=1 in VALID or REQ/IDLE: if_valid<=0 -> HALTED next cycle.
//   - halt=1 in WAIT: drop_q<=1, halt_pend<=1; the pending response is discarded -> HALTED.
//   - halt and redirect in the same cycle: halt wins, redirect ignored. redirect and halt are ignored in HALTED.
//   Arithmetic:
//   - pc_q+4 wraps modulo 2^XLEN.
//   - fetch_count wraps modulo 2^CNT_W.
//   Protocol assumptions on memory:
//   - One outstanding request maximum.
//   - imem_rvalid never arrives in the same cycle as the request.
// TESTING
//   T1 Reset: RESET_PC=0; release reset; memory latency 1 -> imem_req at cycle 2 with addr 0; rvalid at cycle 3;
//      if_valid=1, if_pc=0 at cycle 4; fetch_count=0.
//   T2 Streaming: if_ready=1, memory returns words 0x00500093,0x00108113 -> if_pc 0x0 then 0x4, both transferred;
//      fetch_count=2; next imem_addr=0x8.
//   T3 Redirect in VALID: if_pc=0x4, if_ready=1, redirect_valid=1 with redirect_pc=0x103 -> no transfer, count unchanged;
//      next imem_addr=0x100.
//   T4 Redirect in flight: latency 4; redirect to 0x40 at 2nd WAIT cycle -> stale word discarded (if_valid stays 0);
//      new request addr 0x40; if_pc=0x40.
//   T5 Redirect coincident with rvalid -> response dropped; next imem_req addr=redirect target.
//   T6 Halt in WAIT plus simultaneous redirect -> response dropped; halted=1; imem_req=0 for 20 cycles;
//      async reset low mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the multi-cycle RV32I core.
// The unit keeps one request outstanding to a variable-latency instruction memory.
// It hands each fetched word and its PC to decode through a valid/ready handshake.
// Redirects and halts are honoured at any point of a fetch. A response that belongs
// to an abandoned fetch is dropped.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_inst,
  output logic [XLEN-1:0]  if_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q;
  logic             drop_q;
  logic             halt_pend_q;
  logic [31:0]      inst_q;
  logic [XLEN-1:0]  inst_pc_q;
  logic [CNT_W-1:0] count_q;

  // Decode-side qualifiers. A halt overrides a redirect in the same cycle, and
  // once a halt is pending the fetch unit no longer follows redirects.
  logic redir_take;
  logic accept;
  logic capture;

  assign redir_take = redirect_valid && !halt && !halt_pend_q && (state_q != S_HALTED);
  assign accept     = (state_q == S_VALID) && if_ready && !halt && !redirect_valid;
  assign capture    = (state_q == S_WAIT) && imem_rvalid && !drop_q && !halt_pend_q
                      && !halt && !redirect_valid;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = halt ? S_HALTED : S_REQ;
      S_REQ:    state_d = halt ? S_HALTED : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (halt || halt_pend_q)           state_d = S_HALTED;
          else if (drop_q || redirect_valid) state_d = S_REQ;
          else                               state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (halt)                         state_d = S_HALTED;
        else if (redirect_valid || accept) state_d = S_REQ;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register.
  always_comb begin
    imem_req = (state_q == S_REQ);
    if_valid = (state_q == S_VALID);
    halted   = (state_q == S_HALTED);
  end

  // PC, drop/halt bookkeeping, captured instruction and the transfer counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      inst_q      <= NOP;
      inst_pc_q   <= '0;
      count_q     <= '0;
    end else begin
      if (redir_take)
        pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (capture)
        pc_q <= pc_q + XLEN'(4);

      if (capture) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc_q;
      end

      // The response of the current fetch consumes the drop flag. Otherwise a
      // redirect or halt during an outstanding fetch marks that fetch as stale.
      if ((state_q == S_WAIT) && imem_rvalid)
        drop_q <= 1'b0;
      else if (((state_q == S_REQ) && redir_take) ||
               ((state_q == S_WAIT) && (redir_take || halt)))
        drop_q <= 1'b1;

      if ((state_q == S_WAIT) && halt && !imem_rvalid)
        halt_pend_q <= 1'b1;

      if (accept)
        count_q <= count_q + CNT_W'(1);
    end
  end

  assign imem_addr   = pc_q;
  assign if_inst     = inst_q;
  assign if_pc       = inst_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// The bench drives stimulus and samples outputs on the falling clock edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  // Called on the negedge where the request is visible; returns rvalid lat cycles later.
  task automatic respond(input int lat, input logic [31:0] data);
    repeat (lat) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,    0);
    chk({tag, "_vld"},   if_valid,    0);
    chk({tag, "_inst"},  if_inst,     32'h00000013);
    chk({tag, "_pc"},    if_pc,       0);
    chk({tag, "_halt"},  halted,      0);
    chk({tag, "_cnt"},   fetch_count, 0);
    chk({tag, "_addr"},  imem_addr,   0);
  endtask

  initial begin
    int reqs;
    reset          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs("rst");

    // T1: a stray rvalid in IDLE is ignored; first fetch with latency 1.
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hbad0bad0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t1_idle_vld", if_valid, 0);
    wait_req("t1", 32'h0);
    respond(1, 32'h00500093);
    chk("t1_vld",  if_valid, 1);
    chk("t1_pc",   if_pc, 32'h0);
    chk("t1_inst", if_inst, 32'h00500093);
    chk("t1_cnt",  fetch_count, 0);

    // T2: streaming with if_ready held high.
    if_ready = 1'b1;
    @(negedge clk);
    chk("t2_cnt1", fetch_count, 1);
    chk("t2_vld0", if_valid, 0);
    wait_req("t2a", 32'h4);
    respond(1, 32'h00108113);
    chk("t2_vld",  if_valid, 1);
    chk("t2_pc",   if_pc, 32'h4);
    chk("t2_inst", if_inst, 32'h00108113);
    @(negedge clk);
    chk("t2_cnt2", fetch_count, 2);
    wait_req("t2b", 32'h8);
    respond(1, 32'h00000033);
    chk("t2_pc8", if_pc, 32'h8);

    // T3: redirect in VALID with if_ready high: no transfer, target aligned.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_vld", if_valid, 0);
    chk("t3_cnt", fetch_count, 2);
    wait_req("t3", 32'h100);

    // T4: latency 4, redirect on the second WAIT cycle drops the stale word.
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hdeadbeef;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t4_drop_vld", if_valid, 0);
    wait_req("t4", 32'h40);
    respond(2, 32'h11111111);
    chk("t4_vld",  if_valid, 1);
    chk("t4_pc",   if_pc, 32'h40);
    chk("t4_inst", if_inst, 32'h11111111);
    chk("t4_cnt",  fetch_count, 2);

    // T5: redirect coincident with rvalid.
    @(negedge clk);
    chk("t5_cnt", fetch_count, 3);
    wait_req("t5a", 32'h44);
    @(negedge clk);
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h22222222;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    chk("t5_vld", if_valid, 0);
    wait_req("t5b", 32'h200);

    // T6: halt with simultaneous redirect while waiting.
    @(negedge clk);
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    halt           = 1'b0;
    redirect_valid = 1'b0;
    chk("t6_pend_halted", halted, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h33333333;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t6_halted", halted, 1);
    chk("t6_vld", if_valid, 0);
    chk("t6_cnt", fetch_count, 3);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc    = 32'h500;
      @(negedge clk);
      if (imem_req) reqs++;
    end
    redirect_valid = 1'b0;
    chk("t6_noreq", reqs, 0);
    chk("t6_stay", halted, 1);
    chk("t6_addr", imem_addr, 32'h200);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 reset_outputs("t6_async");

    // Alignment of a redirect in REQ and PC wrap at the top of the space.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wait_req("wr0", 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hfffffffe;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h44444444;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("wr_drop_vld", if_valid, 0);
    wait_req("wr1", 32'hfffffffc);
    respond(1, 32'h55555555);
    chk("wr_pc",   if_pc, 32'hfffffffc);
    chk("wr_inst", if_inst, 32'h55555555);
    @(negedge clk);
    chk("wr_cnt", fetch_count, 1);
    wait_req("wr2", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
